jk_mod_counter: RTL

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

---
 rtl/jk_mod_counter_pkg.sv | 14 +
 rtl/jk_cell.sv | 33 +++
 rtl/jk_mod_counter.sv | 81 ++++++++
 3 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK modulo counter: default width and per-bit JK operation codes.
// The codes are the {J,K} pair driven into each flip-flop.
package jk_mod_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

endpackage

// File: rtl/jk_cell.sv
// Rising-edge JK flip-flop with synchronous active-high clear; 1-edge latency, no backpressure.
// Q_ is always the complement of Q.
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic C,
  input  logic R,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_
);

  logic q_r;

  always_ff @(posedge C) begin
    if (R) begin
      q_r <= 1'b0;
    end else begin
      unique case (jk_op_e'({J, K}))
        JK_HOLD:   q_r <= q_r;
        JK_RESET:  q_r <= 1'b0;
        JK_SET:    q_r <= 1'b1;
        JK_TOGGLE: q_r <= ~q_r;
        default:   q_r <= q_r;
      endcase
    end
  end

  assign Q  = q_r;
  assign Q_ = ~q_r;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-(M+1) counter built from JK cells, with load, combinational TC and sticky OVF.
// Q updates one edge after sampling; TC is zero-latency; no backpressure (every edge acts).
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             UD,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] tog;
  logic             up_wrap;
  logic             dn_wrap;
  logic             wrap;
  logic             ovf_r;
  jk_op_e           op [WIDTH];

  assign up_wrap = (q >= M);
  assign dn_wrap = (q == '0) || (q > M);
  assign wrap    = EN & ~LD & (UD ? up_wrap : dn_wrap);

  // Bits that flip for +/-1 are exactly q ^ (q +/- 1); wraps are handled separately.
  assign tog = UD ? (q ^ (q + ONE)) : (q ^ (q - ONE));

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      op[i] = JK_HOLD;
      if (LD) begin
        op[i] = D[i] ? JK_SET : JK_RESET;
      end else if (EN) begin
        if (wrap) begin
          op[i] = UD ? JK_RESET : (M[i] ? JK_SET : JK_RESET);
        end else begin
          op[i] = tog[i] ? JK_TOGGLE : JK_HOLD;
        end
      end
      {j[i], k[i]} = op[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_cell u_cell (
      .C  (C),
      .R  (R),
      .J  (j[g]),
      .K  (k[g]),
      .Q  (q[g]),
      .Q_ (q_n[g])
    );
  end

  always_ff @(posedge C) begin
    if (R || LD) begin
      ovf_r <= 1'b0;
    end else if (wrap) begin
      ovf_r <= 1'b1;
    end
  end

  assign Q   = q;
  assign Q_  = q_n;
  assign TC  = wrap;
  assign OVF = ovf_r;

endmodule
